uart_cfg: RTL and testbench
===========================

// Module: uart_cfg
// PURPOSE
//  Configurable full-duplex UART: successor to the fixed 8N1 uart/uart_rx/uart_tx trio.
//  Adds runtime-fixed framing parameters (5-8 data bits, none/odd/even parity, 1/2 stop bits),
//  start-bit glitch rejection, parity/framing error detection and an RX FIFO with valid/read handshake.
//  Sits between the pads (rx/tx) and the host logic; TX side keeps the start/tx_active/done_tx handshake.
// PARAMETERS
//  CLK_FREQ    50000000  system clock in Hz
//  BAUD_RATE   19200     bit rate; localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (truncating, must be >=4)
//  DATA_BITS   8         data bits per frame, 5..8, LSB first
//  PARITY      0         0 = none, 1 = odd, 2 = even
//  STOP_BITS   1         1 or 2
//  FIFO_DEPTH  4         RX FIFO entries, power of 2, >=2
// PORTS
//  clk            in   1          system clock
//  rst            in   1          asynchronous reset, active-low
//  rx             in   1          serial input (asynchronous to clk)
//  tx             out  1          serial output, idle high
//  tx_data_in     in   DATA_BITS  byte to send, sampled when start accepted
//  start          in   1          request transmit; accepted only in TX IDLE
//  tx_active      out  1          high from cycle after accept through last stop cycle
//  done_tx        out  1          one-cycle pulse at end of frame
//  rx_data_out    out  DATA_BITS  FIFO head data (0 when rx_valid=0)
//  rx_parity_err  out  1          FIFO head parity error flag (0 when PARITY=0 or empty)
//  rx_frame_err   out  1          FIFO head framing error flag
//  rx_valid       out  1          FIFO not empty
//  rx_read        in   1          pop FIFO head when rx_valid=1; ignored when empty
//  rx_overrun     out  1          one-cycle pulse: completed frame dropped, FIFO full
// BEHAVIOUR
//  Reset (rst=0, async): tx=1, tx_active=0, done_tx=0, rx_valid=0, rx_data_out=0, errs=0,
//   rx_overrun=0, FIFO empty, both FSMs IDLE, rx synchroniser flops =1. Frames in flight are abandoned.
//  rx passes a 2-flop synchroniser; all RX timing below is on the synchronised signal.
//  TX FSM IDLE->START->DATA->PARITY(skipped if PARITY=0)->STOP->IDLE; each bit CLKS_PER_BIT cycles.
//   start=1 in IDLE: latch tx_data_in; next cycle tx=0, tx_active=1. start while busy ignored.
//   Parity bit: even = ^data, odd = ~^data (over DATA_BITS bits only).
//   STOP drives tx=1 for STOP_BITS*CLKS_PER_BIT cycles; on its last cycle FSM moves to IDLE and the
//   next cycle shows done_tx=1, tx_active=0; start in that cycle is accepted (back-to-back frames).
//   Frame = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
//  RX FSM IDLE->START->DATA->PARITY->STOP->IDLE, plus BREAK.
//   IDLE: rx=0 -> START, counter cleared. At CLKS_PER_BIT/2 recheck: rx=1 -> IDLE (glitch, no output).
//   Then sample each bit every CLKS_PER_BIT (mid-bit). Parity error = received != expected.
//   Only first stop bit sampled; 0 -> frame_err and go BREAK (wait for rx=1) before IDLE; 1 -> IDLE.
//   At stop sample: if FIFO not full write {frame_err,parity_err,data}; visible on rx_valid next cycle.
//   Frames with errors are still written. FIFO full: frame dropped, rx_overrun pulses next cycle.
//   FIFO full and rx_read in the same cycle as a write: pop and push both occur, no overrun.
//  FIFO: show-ahead, circular pointers with wrap, log2(FIFO_DEPTH)+1 bit occupancy count.
// TESTING  (bench: CLK_FREQ=1000000, BAUD_RATE=100000 -> CLKS_PER_BIT=10, tx looped to rx)
//  8N1 start with 0xA5 -> tx low 10 cyc, bits 1,0,1,0,0,1,0,1, high 10; done_tx 100 cyc after
//   accept; rx_valid=1 with rx_data_out=0xA5, no errors.
//  PARITY=2 send 0x07 -> parity bit 1, frame 110 cyc; bench flips parity bit -> rx_data_out=0x07,
//   rx_parity_err=1; PARITY=1 0x07 -> parity bit 0.
//  DATA_BITS=7, STOP_BITS=2, send 0x55 then start on done_tx cycle -> two 100-cyc frames, no idle gap,
//   both 0x55 received in order.
//  Bench drives 0x3C with stop bit 0, rx held low 50 cyc -> rx_frame_err=1, data 0x3C; no second
//   frame until rx returns high. rx low 3 cyc only -> no rx_valid.
//  FIFO_DEPTH=4, send 0x01..0x05 without rx_read -> one rx_overrun pulse on 5th; reads yield 0x01..0x04
//   then rx_valid=0; rx_read on last write cycle while full -> no overrun.
//  rst low mid-DATA of TX and RX -> tx=1, tx_active=0, rx_valid=0 immediately; after release 0x5A
//   sent and received correctly.

Source files
------------

// File: rtl/uart_cfg.sv
// Configurable full-duplex UART: 5-8 data bits, none/odd/even parity, 1/2 stop bits, RX FIFO.
// Latency: tx leaves idle the cycle after start is accepted; an RX frame is visible on rx_valid the cycle after its stop-bit sample.
// Backpressure: start is ignored while a frame is being sent; a completed RX frame that finds the FIFO full is dropped and rx_overrun pulses.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-low reset
//   rx / tx                  serial pads (tx idles high)
//   tx_data_in, start        transmit request, data sampled on accept
//   tx_active, done_tx       transmit busy level and end-of-frame pulse
//   rx_data_out, rx_parity_err, rx_frame_err, rx_valid, rx_read
//                            show-ahead FIFO head and pop handshake
//   rx_overrun               one-cycle pulse when a frame was dropped
module uart_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 start,
    output logic                 tx_active,
    output logic                 done_tx,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_read,
    output logic                 rx_overrun
);

    localparam int CPB      = CLK_FREQ / BAUD_RATE;
    localparam int HALF     = CPB / 2;
    localparam int STOP_CYC = STOP_BITS * CPB;
    localparam int CW       = $clog2(STOP_CYC + 1);
    localparam int BW       = $clog2(DATA_BITS);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int EW       = DATA_BITS + 2;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam bit            HAS_PAR   = (PARITY != 0);
    localparam bit            PAR_ODD   = (PARITY == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [2:0]           tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shr_q, tx_shr_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_q, tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shr_d   = tx_shr_q;
        tx_done_d  = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (start) begin
                    tx_state_d = S_START;
                    tx_shr_d   = tx_data_in;
                    tx_cnt_d   = '0;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == IDX_LAST) begin
                        tx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                // All stop bits are one continuous high period.
                if (tx_cnt_q == STOP_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                    tx_done_d  = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_cnt_d   = '0;
            end
        endcase
    end

    // The pad level is registered from the next state so tx is glitch-free
    // and changes in the same cycle the state does.
    always_comb begin
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shr_d[tx_idx_d];
            S_PARITY: tx_d = PAR_ODD ? ~^tx_shr_d : ^tx_shr_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shr_q   <= '0;
            tx_done_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shr_q   <= tx_shr_d;
            tx_done_q  <= tx_done_d;
            tx_q       <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign tx_active = (tx_state_q != S_IDLE);
    assign done_tx   = tx_done_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                 rx_meta_q, rx_s_q;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shr_q, rx_shr_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 push_req;
    logic [EW-1:0]        push_dat;
    logic                 rx_exp_par;

    assign rx_exp_par = PAR_ODD ? ~^rx_shr_q : ^rx_shr_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shr_d   = rx_shr_q;
        rx_perr_d  = rx_perr_q;
        push_req   = 1'b0;
        push_dat   = {~rx_s_q, rx_perr_q, rx_shr_q};
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                // Half-bit recheck: a start edge that has gone high again
                // by mid-bit is treated as noise.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_idx_d   = '0;
                        rx_perr_d  = 1'b0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    rx_shr_d = {rx_s_q, rx_shr_q[DATA_BITS-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_perr_d  = (rx_s_q != rx_exp_par);
                    rx_state_d = S_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                // Only the first stop bit is sampled; a low stop bit means
                // the line may be in a break, so wait for it to recover.
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    push_req   = 1'b1;
                    rx_state_d = rx_s_q ? S_IDLE : S_BREAK;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    rx_state_d = S_IDLE;
                end
            end
            default: begin
                rx_state_d = S_IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shr_q   <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shr_q   <= rx_shr_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO: show-ahead, entry = {frame_err, parity_err, data}
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovr_q;
    logic          fifo_full, fifo_empty, do_push, do_pop, ovr_d;
    logic [EW-1:0] head;

    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_empty = (count_q == '0);
    assign do_pop     = rx_read && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign ovr_d      = push_req && fifo_full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            // Pointers wrap naturally: depth is a power of two.
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign rx_valid      = !fifo_empty;
    assign rx_data_out   = fifo_empty ? '0 : head[DATA_BITS-1:0];
    assign rx_parity_err = !fifo_empty && head[DATA_BITS];
    assign rx_frame_err  = !fifo_empty && head[DATA_BITS+1];
    assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_cfg.sv
`timescale 1ns/1ps
module tb_uart_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] tx_w, start_w, act_w, done_w, valid_w, perr_w, ferr_w, ovr_w, read_w;
    logic [3:0] sel_w, drv_w, rx_w;
    logic [7:0] txd [4];
    logic [7:0] rxd0, rxd1, rxd2;
    logic [6:0] rxd3;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int base;
    logic [15:0] fr;

    // sel=1 loops tx back to rx; sel=0 lets the bench drive the line.
    assign rx_w = (sel_w & tx_w) | (~sel_w & drv_w);

    // u0: 8N1, u1: 8E1, u2: 8O1, u3: 7N2
    uart_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) u0 (
        .clk(clk), .rst(rst), .rx(rx_w[0]), .tx(tx_w[0]), .tx_data_in(txd[0]),
        .start(start_w[0]), .tx_active(act_w[0]), .done_tx(done_w[0]),
        .rx_data_out(rxd0), .rx_parity_err(perr_w[0]), .rx_frame_err(ferr_w[0]),
        .rx_valid(valid_w[0]), .rx_read(read_w[0]), .rx_overrun(ovr_w[0]));

    uart_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY(2)) u1 (
        .clk(clk), .rst(rst), .rx(rx_w[1]), .tx(tx_w[1]), .tx_data_in(txd[1]),
        .start(start_w[1]), .tx_active(act_w[1]), .done_tx(done_w[1]),
        .rx_data_out(rxd1), .rx_parity_err(perr_w[1]), .rx_frame_err(ferr_w[1]),
        .rx_valid(valid_w[1]), .rx_read(read_w[1]), .rx_overrun(ovr_w[1]));

    uart_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY(1)) u2 (
        .clk(clk), .rst(rst), .rx(rx_w[2]), .tx(tx_w[2]), .tx_data_in(txd[2]),
        .start(start_w[2]), .tx_active(act_w[2]), .done_tx(done_w[2]),
        .rx_data_out(rxd2), .rx_parity_err(perr_w[2]), .rx_frame_err(ferr_w[2]),
        .rx_valid(valid_w[2]), .rx_read(read_w[2]), .rx_overrun(ovr_w[2]));

    uart_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .rx(rx_w[3]), .tx(tx_w[3]), .tx_data_in(txd[3][6:0]),
        .start(start_w[3]), .tx_active(act_w[3]), .done_tx(done_w[3]),
        .rx_data_out(rxd3), .rx_parity_err(perr_w[3]), .rx_frame_err(ferr_w[3]),
        .rx_valid(valid_w[3]), .rx_read(read_w[3]), .rx_overrun(ovr_w[3]));

    always @(negedge clk) begin
        if (ovr_w[0] === 1'b1) ovr_cnt++;
    end

    function automatic logic [7:0] rdat(input int n);
        case (n)
            0:       rdat = rxd0;
            1:       rdat = rxd1;
            2:       rdat = rxd2;
            default: rdat = {1'b0, rxd3};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int n, input logic [7:0] d);
        txd[n]     = d;
        start_w[n] = 1'b1;
        @(negedge clk);
        start_w[n] = 1'b0;
    endtask

    task automatic wait_done(input int n, input int c0, input int exp, input string tag);
        int c;
        c = c0;
        while (done_w[n] !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check(tag, c, exp);
    endtask

    task automatic pop_check(input int n, input string tag, input logic [7:0] d,
                             input logic p, input logic f);
        int c;
        c = 0;
        while (valid_w[n] !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_valid"}, valid_w[n], 1);
        check({tag, "_data"}, rdat(n), d);
        check({tag, "_perr"}, perr_w[n], p);
        check({tag, "_ferr"}, ferr_w[n], f);
        read_w[n] = 1'b1;
        @(negedge clk);
        read_w[n] = 1'b0;
    endtask

    // Drives nb bits LSB first, one bit time (10 cycles) each.
    task automatic drive_bits(input int n, input logic [15:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            drv_w[n] = b[i];
            repeat (10) @(negedge clk);
        end
    endtask

    initial begin
        rst     = 1'b0;
        start_w = '0;
        read_w  = '0;
        sel_w   = 4'hF;
        drv_w   = 4'hF;
        for (int i = 0; i < 4; i++) txd[i] = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx", tx_w[0], 1);
        check("rst_active", act_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_valid", valid_w[0], 0);
        check("rst_rxdata", rxd0, 0);
        check("rst_ferr", ferr_w[0], 0);
        check("rst_ovr", ovr_w[0], 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: cycle-exact waveform, done after 100 cycles, loopback receive
        fr = {6'b0, 1'b1, 8'hA5, 1'b0};
        send(0, 8'hA5);
        check("a5_active", act_w[0], 1);
        for (int i = 0; i < 100; i++) begin
            check($sformatf("a5_tx_c%0d", i), tx_w[0], fr[i / 10]);
            check($sformatf("a5_nodone_c%0d", i), done_w[0], 0);
            @(negedge clk);
        end
        check("a5_done", done_w[0], 1);
        check("a5_idle", act_w[0], 0);
        pop_check(0, "a5", 8'hA5, 1'b0, 1'b0);
        check("a5_empty", valid_w[0], 0);
        check("a5_empty_data", rxd0, 0);

        // Even parity 0x07: parity bit 1, 110-cycle frame
        send(1, 8'h07);
        repeat (95) @(negedge clk);
        check("even_par_bit", tx_w[1], 1);
        wait_done(1, 95, 110, "even_len");
        pop_check(1, "even_loop", 8'h07, 1'b0, 1'b0);
        // Same frame with parity bit flipped to 0
        sel_w[1] = 1'b0;
        repeat (5) @(negedge clk);
        drive_bits(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        pop_check(1, "even_flip", 8'h07, 1'b1, 1'b0);
        sel_w[1] = 1'b1;

        // Odd parity 0x07: parity bit 0
        send(2, 8'h07);
        repeat (95) @(negedge clk);
        check("odd_par_bit", tx_w[2], 0);
        wait_done(2, 95, 110, "odd_len");
        pop_check(2, "odd_loop", 8'h07, 1'b0, 1'b0);

        // 7N2 back-to-back frames, restart on the done cycle
        send(3, 8'h55);
        wait_done(3, 0, 100, "b2b_len1");
        check("b2b_idle_on_done", act_w[3], 0);
        send(3, 8'h55);
        check("b2b_active", act_w[3], 1);
        check("b2b_start_bit", tx_w[3], 0);
        wait_done(3, 0, 100, "b2b_len2");
        pop_check(3, "b2b_first", 8'h55, 1'b0, 1'b0);
        pop_check(3, "b2b_second", 8'h55, 1'b0, 1'b0);
        check("b2b_empty", valid_w[3], 0);

        // Framing error: 0x3C with low stop bit, line held low ~50 cycles
        sel_w[0] = 1'b0;
        repeat (5) @(negedge clk);
        drive_bits(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        repeat (10) @(negedge clk);
        pop_check(0, "ferr", 8'h3C, 1'b0, 1'b1);
        repeat (30) @(negedge clk);
        drv_w[0] = 1'b1;
        repeat (120) @(negedge clk);
        check("break_no_frame", valid_w[0], 0);
        // 3-cycle glitch is rejected
        drv_w[0] = 1'b0;
        repeat (3) @(negedge clk);
        drv_w[0] = 1'b1;
        repeat (120) @(negedge clk);
        check("glitch_rejected", valid_w[0], 0);
        sel_w[0] = 1'b1;

        // Overrun: five frames into a 4-deep FIFO
        base = ovr_cnt;
        for (int k = 1; k <= 5; k++) begin
            send(0, 8'(k));
            wait_done(0, 0, 100, $sformatf("ovr_len%0d", k));
            if (k == 4) check("ovr_none_before", ovr_cnt - base, 0);
        end
        repeat (5) @(negedge clk);
        check("ovr_once", ovr_cnt - base, 1);
        for (int k = 1; k <= 4; k++) pop_check(0, $sformatf("ovr_rd%0d", k), 8'(k), 1'b0, 1'b0);
        check("ovr_drained", valid_w[0], 0);

        // Pop in the same cycle as a write into a full FIFO: no overrun
        for (int k = 8'h11; k <= 8'h14; k++) begin
            send(0, 8'(k));
            wait_done(0, 0, 100, $sformatf("sim_len%0h", k));
        end
        base = ovr_cnt;
        send(0, 8'h15);
        repeat (97) @(negedge clk);
        read_w[0] = 1'b1;
        @(negedge clk);
        read_w[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("simul_no_ovr", ovr_cnt - base, 0);
        for (int k = 8'h12; k <= 8'h15; k++) pop_check(0, $sformatf("sim_rd%0h", k), 8'(k), 1'b0, 1'b0);
        check("simul_drained", valid_w[0], 0);

        // Asynchronous reset mid-frame, then normal operation
        send(0, 8'h44);
        wait_done(0, 0, 100, "pre_rst_len");
        send(0, 8'h33);
        repeat (40) @(negedge clk);
        check("pre_rst_valid", valid_w[0], 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx", tx_w[0], 1);
        check("mid_rst_active", act_w[0], 0);
        check("mid_rst_valid", valid_w[0], 0);
        check("mid_rst_rxdata", rxd0, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send(0, 8'h5A);
        wait_done(0, 0, 100, "post_rst_len");
        pop_check(0, "post_rst", 8'h5A, 1'b0, 1'b0);
        repeat (150) @(negedge clk);
        check("post_rst_empty", valid_w[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
